// File: rtl/m2_block_writer_if.sv
// Bundles the block-request, IDCT result RAM and SRAM write signals of the
// block writer. The slave modport is the writer itself; master is its user.
interface m2_block_writer_if;
    logic        start;
    logic [1:0]  segment;
    logic [5:0]  block_col;
    logic [4:0]  block_row;
    logic [6:0]  dpram_address;
    logic [31:0] dpram_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;

    modport slave (
        input  start, segment, block_col, block_row, dpram_read_data,
        output dpram_address, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
    );

    modport master (
        output start, segment, block_col, block_row, dpram_read_data,
        input  dpram_address, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
    );
endinterface

// File: rtl/m2_block_writer.sv
// Writes one reconstructed 8x8 Y/U/V block into the pre-upsampling YUV SRAM
// region: reads 64 signed IDCT results, clips them to 8 bits, packs pixel
// pairs (even pixel in the high byte) and issues 32 SRAM word writes.
module m2_block_writer #(
    parameter int Y_BASE       = 0,
    parameter int U_BASE       = 38400,
    parameter int V_BASE       = 57600,
    parameter int Y_ROW_WORDS  = 160,
    parameter int UV_ROW_WORDS = 80
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    m2_block_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LI0,
        S_LI1,
        S_WR,
        S_CAP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  rd_idx_q, rd_idx_d;          // RAM index currently presented
    logic [4:0]  pair_q, pair_d;              // write number k within the block
    logic [7:0]  even_q, even_d;              // clipped even pixel of current pair
    logic [17:0] row_words_q, row_words_d;    // SRAM words per image row of this segment
    logic [17:0] line_addr_q, line_addr_d;    // address of c=0 in the current block row
    logic [17:0] addr_q, addr_d;              // address of the next write
    logic [17:0] last_addr_q, last_addr_d;    // held SRAM address between writes
    logic [15:0] last_data_q, last_data_d;    // held SRAM data between writes

    logic        req_invalid;
    logic [17:0] req_base;
    logic [17:0] req_row_words;
    logic [17:0] req_line_addr;
    logic [15:0] packed_word;

    // Saturate a signed 32-bit IDCT result into an unsigned 8-bit pixel.
    function automatic logic [7:0] clip8(input logic [31:0] v);
        logic [7:0] r;
        if (v[31])
            r = 8'd0;
        else if (|v[30:8])
            r = 8'hFF;
        else
            r = v[7:0];
        return r;
    endfunction

    // Decode the incoming request: legality check and address of the block's first word.
    always_comb begin
        req_invalid = (bus.segment == 2'd3) || (bus.block_row > 5'd29) ||
                      ((bus.segment == 2'd0) ? (bus.block_col > 6'd39) : (bus.block_col > 6'd19));
        case (bus.segment)
            2'd0:    req_base = 18'(Y_BASE);
            2'd1:    req_base = 18'(U_BASE);
            default: req_base = 18'(V_BASE);
        endcase
        req_row_words = (bus.segment == 2'd0) ? 18'(Y_ROW_WORDS) : 18'(UV_ROW_WORDS);
        req_line_addr = req_base
                      + 18'({bus.block_row, 3'b000}) * req_row_words
                      + 18'({bus.block_col, 2'b00});
    end

    // The odd sample arrives from the RAM in the write cycle itself, so the word is formed combinationally.
    assign packed_word = {even_q, clip8(bus.dpram_read_data)};

    // Next-state and datapath update for the read/capture/write sequence.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        pair_d      = pair_q;
        even_d      = even_q;
        row_words_d = row_words_q;
        line_addr_d = line_addr_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (req_invalid) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_LI0;
                        rd_idx_d    = 7'd0;
                        pair_d      = 5'd0;
                        row_words_d = req_row_words;
                        line_addr_d = req_line_addr;
                        addr_d      = req_line_addr;
                    end
                end
            end
            S_LI0: begin
                rd_idx_d = rd_idx_q + 7'd1;
                state_d  = S_LI1;
            end
            S_LI1: begin
                even_d   = clip8(bus.dpram_read_data);
                rd_idx_d = rd_idx_q + 7'd1;
                state_d  = S_WR;
            end
            S_WR: begin
                last_addr_d = addr_q;
                last_data_d = packed_word;
                pair_d      = pair_q + 5'd1;
                // Four words per block row; after the fourth step down one image row.
                if (pair_q[1:0] == 2'd3) begin
                    line_addr_d = line_addr_q + row_words_q;
                    addr_d      = line_addr_q + row_words_q;
                end else begin
                    addr_d = addr_q + 18'd1;
                end
                if (pair_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    rd_idx_d = rd_idx_q + 7'd1;
                    state_d  = S_CAP;
                end
            end
            S_CAP: begin
                even_d   = clip8(bus.dpram_read_data);
                rd_idx_d = rd_idx_q + 7'd1;
                state_d  = S_WR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rd_idx_q    <= 7'd0;
            pair_q      <= 5'd0;
            even_q      <= 8'd0;
            row_words_q <= 18'd0;
            line_addr_q <= 18'd0;
            addr_q      <= 18'd0;
            last_addr_q <= 18'd0;
            last_data_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            pair_q      <= pair_d;
            even_q      <= even_d;
            row_words_q <= row_words_d;
            line_addr_q <= line_addr_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    assign bus.dpram_address   = rd_idx_q;
    assign bus.SRAM_we_n       = (state_q != S_WR);
    assign bus.SRAM_address    = (state_q == S_WR) ? addr_q : last_addr_q;
    assign bus.SRAM_write_data = (state_q == S_WR) ? packed_word : last_data_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);

endmodule

// File: tb/tb_m2_block_writer.sv
// Directed bench for the block writer: a registered-read RAM model feeds the
// DUT, every SRAM write is logged per block and compared against tables.
module tb_m2_block_writer;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    m2_block_writer_if bus ();

    m2_block_writer dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    // IDCT result RAM: registered read, data valid the cycle after the address
    logic [31:0] mem [0:127];
    always @(posedge clk) bus.dpram_read_data <= mem[bus.dpram_address];

    int checks = 0;
    int errors = 0;

    int wr_addr [0:127];
    int wr_data [0:127];
    int wr_cyc  [0:127];
    int nwr;
    int done_cyc;
    int busy_cnt;

    typedef struct {
        logic [1:0] seg;
        logic [4:0] row;
        logic [5:0] col;
        bit         valid;
        int         first_addr;
        int         last_addr;
    } blk_t;

    typedef struct {
        logic [31:0] ev;
        logic [31:0] od;
        logic [15:0] exp;
    } clp_t;

    blk_t blk [0:8];
    clp_t clp [0:7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int exp_addr(input logic [1:0] seg, input int row, input int col, input int k);
        int base;
        int rw;
        base = (seg == 2'd0) ? 0 : (seg == 2'd1) ? 38400 : 57600;
        rw   = (seg == 2'd0) ? 160 : 80;
        return base + (row * 8 + k / 4) * rw + col * 4 + k % 4;
    endfunction

    task automatic fill_identity();
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
    endtask

    // Issue start in the current cycle (cycle 0) and log cycles 1.. until done or max_cyc.
    task automatic run_block(input logic [1:0] seg, input logic [4:0] row, input logic [5:0] col,
                             input int max_cyc, input int rst_cyc, input bit noise);
        nwr      = 0;
        done_cyc = -1;
        busy_cnt = 0;
        bus.start     = 1'b1;
        bus.segment   = seg;
        bus.block_row = row;
        bus.block_col = col;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.segment   = ~seg;
        bus.block_row = ~row;
        bus.block_col = ~col;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (!bus.SRAM_we_n) begin
                if (nwr < 128) begin
                    wr_addr[nwr] = int'(bus.SRAM_address);
                    wr_data[nwr] = int'(bus.SRAM_write_data);
                    wr_cyc[nwr]  = cyc;
                end
                nwr++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            resetn    = (cyc != rst_cyc);
            bus.start = noise && (cyc % 13 == 0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        resetn    = 1'b1;
        $display("block seg=%0d row=%0d col=%0d: writes=%0d done_cycle=%0d busy_cycles=%0d",
                 seg, row, col, nwr, done_cyc, busy_cnt);
    endtask

    // Advance one cycle and confirm the writer sits idle.
    task automatic idle_check(input string name);
        @(posedge clk); #1;
        check({name, "_idle_busy"}, bus.busy, 0);
        check({name, "_idle_done"}, bus.done, 0);
        check({name, "_idle_we_n"}, bus.SRAM_we_n, 1);
    endtask

    function automatic int wa(input int k);
        return (k < nwr && k < 128) ? wr_addr[k] : -1;
    endfunction

    function automatic int wd(input int k);
        return (k < nwr && k < 128) ? wr_data[k] : -1;
    endfunction

    function automatic int wc(input int k);
        return (k < nwr && k < 128) ? wr_cyc[k] : -1;
    endfunction

    initial begin
        int n_first;

        blk[0] = '{2'd0, 5'd0,  6'd0,  1'b1, 0,     1123};
        blk[1] = '{2'd1, 5'd29, 6'd19, 1'b1, 57036, 57599};
        blk[2] = '{2'd2, 5'd0,  6'd0,  1'b1, 57600, 58163};
        blk[3] = '{2'd0, 5'd29, 6'd39, 1'b1, 37276, 38399};
        blk[4] = '{2'd2, 5'd29, 6'd19, 1'b1, 76236, 76799};
        blk[5] = '{2'd3, 5'd0,  6'd0,  1'b0, 0,     0};
        blk[6] = '{2'd1, 5'd0,  6'd20, 1'b0, 0,     0};
        blk[7] = '{2'd0, 5'd30, 6'd0,  1'b0, 0,     0};
        blk[8] = '{2'd0, 5'd0,  6'd40, 1'b0, 0,     0};

        clp[0] = '{32'hFFFFFFFB, 32'd300,      16'h00FF};
        clp[1] = '{32'h00000012, 32'h00000034, 16'h1234};
        clp[2] = '{32'd255,      32'd256,      16'hFFFF};
        clp[3] = '{32'h80000000, 32'h7FFFFFFF, 16'h00FF};
        clp[4] = '{32'd0,        32'd0,        16'h0000};
        clp[5] = '{32'd1,        32'd254,      16'h01FE};
        clp[6] = '{32'hFFFFFFFF, 32'h00000100, 16'h00FF};
        clp[7] = '{32'h00010080, 32'h0000007F, 16'hFF7F};

        fill_identity();
        bus.start     = 1'b0;
        bus.segment   = 2'd0;
        bus.block_row = 5'd0;
        bus.block_col = 6'd0;
        resetn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dpram_address", bus.dpram_address, 0);
        check("rst_SRAM_address", bus.SRAM_address, 0);
        check("rst_SRAM_write_data", bus.SRAM_write_data, 0);
        check("rst_SRAM_we_n", bus.SRAM_we_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Address generation and request validation over the block table
        for (int b = 0; b < 9; b++) begin
            run_block(blk[b].seg, blk[b].row, blk[b].col, 80, -1, 1'b0);
            if (blk[b].valid) begin
                check($sformatf("blk%0d_writes", b), nwr, 32);
                check($sformatf("blk%0d_done_cycle", b), done_cyc, 66);
                check($sformatf("blk%0d_busy_cycles", b), busy_cnt, 66);
                check($sformatf("blk%0d_first_addr", b), wa(0), blk[b].first_addr);
                check($sformatf("blk%0d_last_addr", b), wa(31), blk[b].last_addr);
                for (int k = 0; k < 32; k++) begin
                    check($sformatf("blk%0d_w%0d_addr", b, k), wa(k),
                          exp_addr(blk[b].seg, int'(blk[b].row), int'(blk[b].col), k));
                    check($sformatf("blk%0d_w%0d_data", b, k), wd(k), ((2 * k) << 8) | (2 * k + 1));
                    check($sformatf("blk%0d_w%0d_cycle", b, k), wc(k), 3 + 2 * k);
                end
            end else begin
                check($sformatf("blk%0d_inv_writes", b), nwr, 0);
                check($sformatf("blk%0d_inv_done_cycle", b), done_cyc, 1);
                check($sformatf("blk%0d_inv_busy_cycles", b), busy_cnt, 1);
            end
            idle_check($sformatf("blk%0d", b));
        end

        // Clipping and packing: the eight pairs repeat across the block
        for (int k = 0; k < 32; k++) begin
            mem[2 * k]     = clp[k % 8].ev;
            mem[2 * k + 1] = clp[k % 8].od;
        end
        run_block(2'd0, 5'd0, 6'd0, 80, -1, 1'b0);
        check("clip_writes", nwr, 32);
        for (int k = 0; k < 32; k++)
            check($sformatf("clip_w%0d_data", k), wd(k), clp[k % 8].exp);
        idle_check("clip");
        fill_identity();

        // Start pulses while busy must be ignored
        run_block(2'd0, 5'd3, 6'd5, 80, -1, 1'b1);
        check("noise_writes", nwr, 32);
        check("noise_done_cycle", done_cyc, 66);
        check("noise_first_addr", wa(0), exp_addr(2'd0, 3, 5, 0));
        idle_check("noise");

        // Reset in cycle 20 aborts the block without a done pulse
        run_block(2'd0, 5'd0, 6'd0, 30, 20, 1'b0);
        check("rst_mid_done", done_cyc, -1);
        check("rst_mid_writes", nwr, 9);
        check("rst_mid_last_write_cycle", wc(8), 19);
        check("rst_mid_busy_cycles", busy_cnt, 20);
        run_block(2'd0, 5'd1, 6'd2, 80, -1, 1'b0);
        check("after_rst_writes", nwr, 32);
        check("after_rst_done_cycle", done_cyc, 66);
        check("after_rst_first_addr", wa(0), 1288);
        idle_check("after_rst");

        // Back-to-back V blocks: second start in the cycle right after done
        run_block(2'd2, 5'd0, 6'd0, 80, -1, 1'b0);
        n_first = nwr;
        check("b2b_first_done_cycle", done_cyc, 66);
        @(posedge clk); #1;
        check("b2b_gap_busy", bus.busy, 0);
        run_block(2'd2, 5'd0, 6'd1, 80, -1, 1'b0);
        check("b2b_second_first_addr", wa(0), 57604);
        check("b2b_second_done_cycle", done_cyc, 66);
        check("b2b_total_writes", n_first + nwr, 64);
        idle_check("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/m2_block_writer.md
Name: m2_block_writer

Overview:
- Upstream neighbour of the colour-space/upsampling stage: writes one IDCT-reconstructed 8x8 block of Y, U or V samples into the pre-upsampling YUV SRAM region, where the next stage reads it.
- Reads 64 signed 32-bit results from the IDCT result dual-port RAM, clips each to 8 bits, packs pixel pairs into 16-bit words, and writes 32 SRAM words at addresses generated from the block position and segment.

Parameters:
- Y_BASE, 0, SRAM word address of the Y segment.
- U_BASE, 38400, SRAM word address of the U segment.
- V_BASE, 57600, SRAM word address of the V segment.
- Y_ROW_WORDS, 160, words per Y image row (320 pixels / 2).
- UV_ROW_WORDS, 80, words per U/V image row (160 pixels / 2).

Ports:
- CLOCK_50_I  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in S_IDLE.
- segment  input  2  0=Y, 1=U, 2=V, 3=invalid; latched on accepted start.
- block_col  input  6  block column (Y 0..39, U/V 0..19); latched on accepted start.
- block_row  input  5  block row 0..29; latched on accepted start.
- dpram_address  output  7  IDCT result RAM read index, r*8+c.
- dpram_read_data  input  32  signed result; registered RAM, valid the cycle after the address.
- SRAM_address  output  18  SRAM word address.
- SRAM_write_data  output  16  packed pixel pair.
- SRAM_we_n  output  1  active-low write enable.
- busy  output  1  high while a block is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: dpram_address=0, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, busy=0, done=0, FSM=S_IDLE. Reset takes priority over every other event.
- Reset mid-block: FSM returns to S_IDLE at that edge. SRAM_we_n=1 from the next cycle. No done pulse is generated.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in S_IDLE. start is ignored whenever busy=1.
- Invalid request: segment=3, block_row>29, block_col>39 (Y), or block_col>19 (U/V).
  - No RAM reads and no SRAM writes occur.
  - busy=1 and done=1 in cycle 1 only, then return to S_IDLE.
- Valid request: FSM states S_IDLE -> S_LI0 -> S_LI1 -> (S_WR <-> S_CAP) -> S_DONE -> S_IDLE.
  - S_LI0 (cycle 1): present index 0.
  - S_LI1 (cycle 2): capture even sample; present index 1.
  - S_WR (cycles 3, 5, ..., 65): SRAM_we_n=0 with the packed word for the pair; present the next even index.
  - S_CAP (cycles 4, ..., 64): SRAM_we_n=1; capture even sample; present the odd index.
  - S_DONE (cycle 66): done=1, SRAM_we_n=1, busy=1.
  - busy is high in cycles 1..66 inclusive.
- Write k (k=0..31) occurs in cycle 3+2k, with r=k/4 and c=k%4.
  - Even pixel at RAM index r*8+2c; odd pixel at RAM index r*8+2c+1.
  - SRAM_address = base + (block_row*8 + r)*row_words + block_col*4 + c.
  - base is Y_BASE/U_BASE/V_BASE; row_words is Y_ROW_WORDS for Y, UV_ROW_WORDS otherwise.
  - Arithmetic is unsigned in at least 18 bits. No wrap occurs for legal inputs: maximum is 57599 for U and 38399 for Y.
- Clip, applied per sample: bit31=1 -> 0; value>255 -> 255; otherwise value[7:0].
- Packing: SRAM_write_data = {clip(even), clip(odd)}, with the even pixel in [15:8].
- Outside write cycles, SRAM_address and SRAM_write_data hold their last values. They are don't-care while SRAM_we_n=1.
- Inputs are not required stable after cycle 0.
- Back-to-back operation: a start in the cycle after done (S_IDLE) is accepted; there is no dead cycle beyond S_IDLE.

Test Plan:
- Y block, row 0, col 0; RAM holds index i = i -> 32 writes in cycles 3..65.
  - Addresses 0,1,2,3,160,...,1123.
  - First word 0x0001, last word 0x3E3F; done=1 in cycle 66 only.
- U block, row 29, col 19 -> first address 38400+232*80+76=57036; last address 57599.
- Clip/pack with pairs (-5, 300), (0x12, 0x34), (255, 256), (0x80000000, 0x7FFFFFFF) -> words 0x00FF, 0x1234, 0xFFFF, 0x00FF.
- Invalid requests:
  - segment=3 -> no we_n low, done in cycle 1.
  - U with block_col=20 -> same response.
- Reset control:
  - resetn=0 in cycle 20 -> we_n=1 from cycle 21, no done; next start runs the full 66-cycle sequence.
  - start pulses while busy -> ignored, write count stays 32.
- Back-to-back V blocks, col 0 then col 1 -> second first-write address 57604, exactly 64 writes in total.
